cache_main_fsm_wb: RTL
======================

// Module: cache_main_fsm_wb
// PURPOSE
// Main control FSM for a parametrised N-way write-back cache (I- or D-side). Drives lookup,
// store-hit write, dirty-victim write-back, line refill, uncached read/write and CACOP.
// Sits between the cache datapath (tag/data RAMs, request/miss/write buffers) and the AXI bridge.
// PARAMETERS
// WAYS        4   number of ways; all way vectors are WAYS-bit one-hot
// LINE_WORDS  16  words per line; cached burst length = LINE_WORDS-1
// EXC_W       7   width of exception vector
// PORTS
// clk  in  1  clock
// rstn  in  1  synchronous active-low reset
// valid  in  1  new request in request buffer; op  in  1  0=read 1=write
// uncache  in  1  request is uncached; cache_hit  in  1  tag hit this cycle
// hit  in  WAYS  one-hot hit way; lru_way_sel  in  WAYS  one-hot victim way
// victim_dirty  in  1  selected victim/CACOP way is valid and dirty
// r_rdy  in  1  AXI read accepted; fill_finish  in  1  last refill beat this cycle
// w_rdy  in  1  AXI write accepted; w_finish  in  1  write response received
// cacop_en  in  1  CACOP request; cacop_code  in  2  00 store-tag 01 index-inv 10 hit-inv
// cacop_way  in  $clog2(WAYS)  way index for codes 00/01; exception  in  EXC_W  nonzero=abort
// way_visit  out  WAYS  LRU update way; way_sel_en  out  1  LRU update strobe
// rbuf_we/pbuf_we/mbuf_we/wbuf_we  out  1 each  request/pipeline/miss/write-back buffer load
// rdata_sel  out  1  return data from RAM (1) vs refill buffer (0)
// mem_we  out  WAYS  data RAM write; tagv_we  out  WAYS  tag RAM write; tagv_clear  out  1  write V=0
// dirty_set  out  1  set dirty on written way; dirty_clear  out  1  clear dirty on written way
// r_req  out  1; r_length  out  8; r_data_ready  out  1  AXI read channel controls
// w_req  out  1; w_length  out  8  AXI write channel controls
// data_valid/cache_ready/cacop_ready/cacop_complete  out  1 each  core-side handshakes
// BEHAVIOUR
// States: IDLE, LOOKUP, WB_REQ, WB_WAIT, REPLACE, REFILL, UC_WRITE, CACOP, EXTRA_READY. Outputs combinational from state+inputs.
// Reset: state=IDLE; outputs then rbuf_we=cache_ready=cacop_ready=1, r_length=w_length=LINE_WORDS-1, all else 0.
// IDLE: cacop_en->CACOP (priority) else valid->LOOKUP.
// LOOKUP: exception!=0 -> data_valid=1, ->IDLE. Else pbuf_we=rdata_sel=1:
//  cached hit: data_valid, rbuf_we, cache_ready, cacop_ready, way_sel_en=1, way_visit=hit;
//   write hit also mem_we=hit, dirty_set=1; next as IDLE (back-to-back hits, 1-cycle throughput).
//  cached miss: mbuf_we=1; victim_dirty -> wbuf_we=1, ->WB_REQ; else ->REPLACE.
//  uncached read -> mbuf_we=1, ->REPLACE; uncached write -> mbuf_we=1, ->UC_WRITE.
// WB_REQ: w_req=1, w_length=LINE_WORDS-1; w_rdy -> WB_WAIT. WB_WAIT: w_finish -> REPLACE, or CACOP if wb_from_cacop.
// REPLACE: r_req=1, r_length = uncache ? 0 : LINE_WORDS-1; r_rdy -> REFILL.
// REFILL: r_data_ready=1; on fill_finish & !uncache: mem_we=tagv_we=way_visit=lru_way_sel, way_sel_en=1,
//  dirty_set=op, dirty_clear=!op; ->EXTRA_READY. Write data merges in datapath.
// UC_WRITE: w_req=1, w_length=0 until w_rdy; then hold w_req=0 until w_finish -> EXTRA_READY (internal sub-flag).
// EXTRA_READY: data_valid, rbuf_we, cache_ready, cacop_ready, cacop_complete=1; next as IDLE.
// CACOP: exception!=0 -> cacop_complete=1, ->IDLE. Target way = code 10 ? hit : onehot(cacop_way).
//  code 00: tagv_clear, tagv_we=target, dirty_clear, data_valid; ->EXTRA_READY (no write-back).
//  code 01/10 with victim_dirty & !wb_from_cacop: wbuf_we=1, set wb_from_cacop, ->WB_REQ.
//  else tagv_clear, tagv_we=target, dirty_clear, data_valid, clear wb_from_cacop; ->EXTRA_READY.
//  code 10 with hit==0: no write, ->EXTRA_READY. code 11: no-op, ->EXTRA_READY.
// wb_from_cacop: 1-bit reg, reset 0. Only one AXI transaction outstanding per channel.
// Simultaneous cacop_en & valid: CACOP wins; valid held by requester. Reset mid-burst: state->IDLE
//  immediately, flags cleared; AXI side must be reset by same rstn. Illegal state -> IDLE.
// CONFIGURATION
// CACHE_FSM_PERF_EN defined: adds outputs perf_hit[31:0], perf_miss[31:0], perf_wb[31:0]; increment on
//  cached LOOKUP hit, cached LOOKUP miss, WB_WAIT w_finish; wrap at 2^32; reset 0. Undefined: ports absent.
// TESTING
// read miss clean, WAYS=4, lru=0100 -> REPLACE r_length=15; 16 beats; fill_finish: mem_we=tagv_we=0100, dirty_clear.
// write hit hit=0010 -> same cycle mem_we=0010, dirty_set=1, data_valid=1; back-to-back valid stays LOOKUP.
// read miss victim_dirty=1 -> wbuf_we, WB_REQ w_length=15; w_rdy, w_finish after 5 cycles -> REPLACE then REFILL.
// uncached write -> UC_WRITE w_length=0; w_finish -> EXTRA_READY cacop_complete=data_valid=1, no mem_we.
// CACOP code 01, cacop_way=3, dirty -> WB_REQ; after w_finish back to CACOP: tagv_we=1000, tagv_clear=1.
// LOOKUP with exception=7'h04 -> data_valid=1, no mbuf_we, IDLE next; rstn low during REFILL -> IDLE next cycle.

Source files
------------

// File: rtl/cache_main_fsm_wb_if.sv
// Control bundle between the cache main FSM (master) and the datapath / AXI bridge (slave).
interface cache_main_fsm_wb_if #(
    parameter int WAYS  = 4,
    parameter int EXC_W = 7
);
    localparam int WIDX_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic              valid, op, uncache, cache_hit;
    logic [WAYS-1:0]   hit, lru_way_sel;
    logic              victim_dirty;
    logic              r_rdy, fill_finish, w_rdy, w_finish;
    logic              cacop_en;
    logic [1:0]        cacop_code;
    logic [WIDX_W-1:0] cacop_way;
    logic [EXC_W-1:0]  exception;

    logic [WAYS-1:0]   way_visit;
    logic              way_sel_en;
    logic              rbuf_we, pbuf_we, mbuf_we, wbuf_we, rdata_sel;
    logic [WAYS-1:0]   mem_we, tagv_we;
    logic              tagv_clear, dirty_set, dirty_clear;
    logic              r_req;
    logic [7:0]        r_length;
    logic              r_data_ready;
    logic              w_req;
    logic [7:0]        w_length;
    logic              data_valid, cache_ready, cacop_ready, cacop_complete;

    modport master (
        input  valid, op, uncache, cache_hit, hit, lru_way_sel, victim_dirty,
               r_rdy, fill_finish, w_rdy, w_finish, cacop_en, cacop_code, cacop_way, exception,
        output way_visit, way_sel_en, rbuf_we, pbuf_we, mbuf_we, wbuf_we, rdata_sel,
               mem_we, tagv_we, tagv_clear, dirty_set, dirty_clear, r_req, r_length,
               r_data_ready, w_req, w_length, data_valid, cache_ready, cacop_ready, cacop_complete
    );

    modport slave (
        output valid, op, uncache, cache_hit, hit, lru_way_sel, victim_dirty,
               r_rdy, fill_finish, w_rdy, w_finish, cacop_en, cacop_code, cacop_way, exception,
        input  way_visit, way_sel_en, rbuf_we, pbuf_we, mbuf_we, wbuf_we, rdata_sel,
               mem_we, tagv_we, tagv_clear, dirty_set, dirty_clear, r_req, r_length,
               r_data_ready, w_req, w_length, data_valid, cache_ready, cacop_ready, cacop_complete
    );
endinterface

// File: rtl/cache_main_fsm_wb.sv
// Main control FSM of an N-way write-back cache: lookup, write-back, refill, uncached and CACOP.
// Optional CACHE_FSM_PERF_EN adds hit/miss/write-back event counters.
module cache_main_fsm_wb #(
    parameter int WAYS       = 4,
    parameter int LINE_WORDS = 16,
    parameter int EXC_W      = 7
) (
    input  logic                  clk,
    input  logic                  rstn,
    cache_main_fsm_wb_if.master   bus
`ifdef CACHE_FSM_PERF_EN
    ,
    output logic [31:0]           perf_hit,
    output logic [31:0]           perf_miss,
    output logic [31:0]           perf_wb
`endif
);
    localparam logic [7:0] FULL_LEN = 8'(LINE_WORDS - 1);

    typedef enum logic [3:0] {
        IDLE, LOOKUP, WB_REQ, WB_WAIT, REPLACE, REFILL, UC_WRITE, CACOP, EXTRA_READY
    } state_t;

    state_t          state, state_nxt, idle_nxt;
    logic            wb_from_cacop, wb_cacop_nxt;
    logic            uc_w_sent, uc_sent_nxt;
    logic [WAYS-1:0] onehot_way, tgt_way;
    logic            exc;

    assign exc      = |bus.exception;
    assign idle_nxt = bus.cacop_en ? CACOP : (bus.valid ? LOOKUP : IDLE);

    always_comb begin
        onehot_way = '0;
        onehot_way[bus.cacop_way] = 1'b1;
        tgt_way = (bus.cacop_code == 2'b10) ? bus.hit : onehot_way;
    end

    always_comb begin
        state_nxt          = state;
        wb_cacop_nxt       = wb_from_cacop;
        uc_sent_nxt        = uc_w_sent;
        bus.way_visit      = '0;
        bus.way_sel_en     = 1'b0;
        bus.rbuf_we        = 1'b0;
        bus.pbuf_we        = 1'b0;
        bus.mbuf_we        = 1'b0;
        bus.wbuf_we        = 1'b0;
        bus.rdata_sel      = 1'b0;
        bus.mem_we         = '0;
        bus.tagv_we        = '0;
        bus.tagv_clear     = 1'b0;
        bus.dirty_set      = 1'b0;
        bus.dirty_clear    = 1'b0;
        bus.r_req          = 1'b0;
        bus.r_length       = FULL_LEN;
        bus.r_data_ready   = 1'b0;
        bus.w_req          = 1'b0;
        bus.w_length       = FULL_LEN;
        bus.data_valid     = 1'b0;
        bus.cache_ready    = 1'b0;
        bus.cacop_ready    = 1'b0;
        bus.cacop_complete = 1'b0;

        case (state)
            IDLE: begin
                bus.rbuf_we     = 1'b1;
                bus.cache_ready = 1'b1;
                bus.cacop_ready = 1'b1;
                state_nxt       = idle_nxt;
            end
            LOOKUP: begin
                if (exc) begin
                    bus.data_valid = 1'b1;
                    state_nxt      = IDLE;
                end else begin
                    bus.pbuf_we   = 1'b1;
                    bus.rdata_sel = 1'b1;
                    if (bus.uncache) begin
                        bus.mbuf_we = 1'b1;
                        state_nxt   = bus.op ? UC_WRITE : REPLACE;
                    end else if (bus.cache_hit) begin
                        // Hit completes here so a following request can be looked up next cycle.
                        bus.data_valid  = 1'b1;
                        bus.rbuf_we     = 1'b1;
                        bus.cache_ready = 1'b1;
                        bus.cacop_ready = 1'b1;
                        bus.way_sel_en  = 1'b1;
                        bus.way_visit   = bus.hit;
                        if (bus.op) begin
                            bus.mem_we    = bus.hit;
                            bus.dirty_set = 1'b1;
                        end
                        state_nxt = idle_nxt;
                    end else begin
                        bus.mbuf_we = 1'b1;
                        if (bus.victim_dirty) begin
                            bus.wbuf_we = 1'b1;
                            state_nxt   = WB_REQ;
                        end else begin
                            state_nxt   = REPLACE;
                        end
                    end
                end
            end
            WB_REQ: begin
                bus.w_req = 1'b1;
                if (bus.w_rdy) state_nxt = WB_WAIT;
            end
            WB_WAIT: begin
                if (bus.w_finish) state_nxt = wb_from_cacop ? CACOP : REPLACE;
            end
            REPLACE: begin
                bus.r_req    = 1'b1;
                bus.r_length = bus.uncache ? 8'd0 : FULL_LEN;
                if (bus.r_rdy) state_nxt = REFILL;
            end
            REFILL: begin
                bus.r_data_ready = 1'b1;
                if (bus.fill_finish) begin
                    if (!bus.uncache) begin
                        bus.mem_we      = bus.lru_way_sel;
                        bus.tagv_we     = bus.lru_way_sel;
                        bus.way_visit   = bus.lru_way_sel;
                        bus.way_sel_en  = 1'b1;
                        bus.dirty_set   = bus.op;
                        bus.dirty_clear = !bus.op;
                    end
                    state_nxt = EXTRA_READY;
                end
            end
            UC_WRITE: begin
                // uc_w_sent splits the state into "address not yet accepted" and "awaiting response".
                bus.w_length = 8'd0;
                bus.w_req    = !uc_w_sent;
                if (!uc_w_sent && bus.w_rdy) uc_sent_nxt = 1'b1;
                if (uc_w_sent && bus.w_finish) begin
                    uc_sent_nxt = 1'b0;
                    state_nxt   = EXTRA_READY;
                end
            end
            CACOP: begin
                if (exc) begin
                    bus.cacop_complete = 1'b1;
                    wb_cacop_nxt       = 1'b0;
                    state_nxt          = IDLE;
                end else begin
                    state_nxt    = EXTRA_READY;
                    wb_cacop_nxt = 1'b0;
                    case (bus.cacop_code)
                        2'b00: begin
                            bus.tagv_clear  = 1'b1;
                            bus.tagv_we     = tgt_way;
                            bus.dirty_clear = 1'b1;
                            bus.data_valid  = 1'b1;
                        end
                        2'b01, 2'b10: begin
                            if (bus.cacop_code == 2'b10 && bus.hit == '0) begin
                                state_nxt = EXTRA_READY;
                            end else if (bus.victim_dirty && !wb_from_cacop) begin
                                bus.wbuf_we  = 1'b1;
                                wb_cacop_nxt = 1'b1;
                                state_nxt    = WB_REQ;
                            end else begin
                                bus.tagv_clear  = 1'b1;
                                bus.tagv_we     = tgt_way;
                                bus.dirty_clear = 1'b1;
                                bus.data_valid  = 1'b1;
                            end
                        end
                        default: state_nxt = EXTRA_READY;
                    endcase
                end
            end
            EXTRA_READY: begin
                bus.data_valid     = 1'b1;
                bus.rbuf_we        = 1'b1;
                bus.cache_ready    = 1'b1;
                bus.cacop_ready    = 1'b1;
                bus.cacop_complete = 1'b1;
                state_nxt          = idle_nxt;
            end
            default: begin
                state_nxt    = IDLE;
                wb_cacop_nxt = 1'b0;
                uc_sent_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= IDLE;
            wb_from_cacop <= 1'b0;
            uc_w_sent     <= 1'b0;
        end else begin
            state         <= state_nxt;
            wb_from_cacop <= wb_cacop_nxt;
            uc_w_sent     <= uc_sent_nxt;
        end
    end

`ifdef CACHE_FSM_PERF_EN
    logic ev_hit, ev_miss, ev_wb;
    assign ev_hit  = (state == LOOKUP) && !exc && !bus.uncache && bus.cache_hit;
    assign ev_miss = (state == LOOKUP) && !exc && !bus.uncache && !bus.cache_hit;
    assign ev_wb   = (state == WB_WAIT) && bus.w_finish;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            perf_hit  <= '0;
            perf_miss <= '0;
            perf_wb   <= '0;
        end else begin
            if (ev_hit)  perf_hit  <= perf_hit + 32'd1;
            if (ev_miss) perf_miss <= perf_miss + 32'd1;
            if (ev_wb)   perf_wb   <= perf_wb + 32'd1;
        end
    end
`endif
endmodule
